barrel_normalizer: RTL and testbench

Iterative left/right normalizer: the inverse operation of the `barrier_shifter` block. Given a word, it finds the shift amount that brings the first set bit to the MSB (direction "L") or to the LSB (direction "R"), and returns both the normalized word and that shift amount. It runs a binary-search shift of one stage per cycle behind valid/ready handshakes, and sits in front of the FP/priority datapaths that feed `barrier_shifter`.

---
 rtl/barrel_pkg.sv | 14 +
 rtl/barrel_normalizer_if.sv | 29 ++
 rtl/barrel_normalizer.sv | 120 ++++++++++++
 tb/tb_barrel_normalizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_normalizer shared types: FSM states and direction codes.
// Optional feature macro: BARREL_NORMALIZER_EARLY_EXIT_EN.
package barrel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] DIR_L = "L";
  localparam logic [7:0] DIR_R = "R";

endpackage

// File: rtl/barrel_normalizer_if.sv
// barrel_normalizer handshake bundle: input word in, normalized result out.
// Optional feature macro: BARREL_NORMALIZER_EARLY_EXIT_EN.
interface barrel_normalizer_if #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SW-1:0]    out_shift;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_shift, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_shift, out_zero
  );

endinterface

// File: rtl/barrel_normalizer.sv
// Iterative leading/trailing-zero normalizer, one binary-search stage per cycle.
// Optional feature macro: BARREL_NORMALIZER_EARLY_EXIT_EN (exit once normalized).
module barrel_normalizer
  import barrel_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [7:0] DIRECTION = DIR_L
) (
  input logic          clk,
  input logic          rst,
  barrel_normalizer_if.slave bus
);

  localparam int SW   = $clog2(WIDTH);
  localparam bit LEFT = (DIRECTION == DIR_L);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_acc;
  logic [SW-1:0]    r_k;
  logic             r_zero;

  logic [31:0]      w_s;
  logic             w_hit;
  logic [WIDTH-1:0] w_stage;
  logic             w_norm_in;
  logic             w_norm_stage;
  logic             w_accept;
  logic             w_in_zero;

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_work;
  assign bus.out_shift = r_acc;
  assign bus.out_zero  = r_zero;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_in_zero = (bus.in_data == '0);

  // One stage: shift by 2^k when the leading (or trailing) 2^k bits are zero.
  // A stage as wide as the word can only pass for zero, which never gets here.
  always_comb begin
    w_s     = 32'd1 << r_k;
    w_hit   = 1'b0;
    w_stage = r_work;
    if (w_s < 32'(WIDTH)) begin
      if (LEFT) begin
        w_hit = ((r_work >> (32'(WIDTH) - w_s)) == '0);
      end else begin
        w_hit = ((r_work << (32'(WIDTH) - w_s)) == '0);
      end
    end
    if (w_hit) begin
      w_stage = LEFT ? (r_work << w_s) : (r_work >> w_s);
    end
    w_norm_stage = LEFT ? w_stage[WIDTH-1] : w_stage[0];
    w_norm_in    = LEFT ? bus.in_data[WIDTH-1] : bus.in_data[0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_zero) w_next = DONE;
`ifdef BARREL_NORMALIZER_EARLY_EXIT_EN
          else if (w_norm_in) w_next = DONE;
`endif
          else w_next = BUSY;
        end
      end
      BUSY: begin
        if (r_k == '0) w_next = DONE;
`ifdef BARREL_NORMALIZER_EARLY_EXIT_EN
        else if (w_norm_stage) w_next = DONE;
`endif
      end
      DONE: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Work register, shift accumulator and stage index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_acc  <= '0;
      r_k    <= '0;
      r_zero <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_work <= bus.in_data;
            r_acc  <= '0;
            r_k    <= SW'(SW - 1);
            r_zero <= w_in_zero;
          end
        end
        BUSY: begin
          r_work <= w_stage;
          if (w_hit) r_acc <= r_acc + w_s[SW-1:0];
          r_k <= r_k - SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_normalizer.sv
// Self-checking bench: four normalizers (8/12 bits, L/R) vs a zero-count model.
// Honours BARREL_NORMALIZER_EARLY_EXIT_EN for the expected latency.
module tb_barrel_normalizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  barrel_normalizer_if #(.WIDTH(8))  b0 ();
  barrel_normalizer_if #(.WIDTH(8))  b1 ();
  barrel_normalizer_if #(.WIDTH(12)) b2 ();
  barrel_normalizer_if #(.WIDTH(12)) b3 ();

  barrel_normalizer #(.WIDTH(8),  .DIRECTION("L")) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  barrel_normalizer #(.WIDTH(8),  .DIRECTION("R")) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  barrel_normalizer #(.WIDTH(12), .DIRECTION("L")) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));
  barrel_normalizer #(.WIDTH(12), .DIRECTION("R")) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int w_of(int sel);
    return (sel < 2) ? 8 : 12;
  endfunction

  function automatic bit left_of(int sel);
    return (sel == 0) || (sel == 2);
  endfunction

  function automatic logic [11:0] mask_of(int sel);
    logic [11:0] m;
    m = 12'hFFF;
    return m >> (12 - w_of(sel));
  endfunction

  task automatic set_in(int sel, logic v, logic [11:0] d, logic r);
    case (sel)
      0: begin b0.in_valid = v; b0.in_data = d[7:0]; b0.out_ready = r; end
      1: begin b1.in_valid = v; b1.in_data = d[7:0]; b1.out_ready = r; end
      2: begin b2.in_valid = v; b2.in_data = d; b2.out_ready = r; end
      default: begin b3.in_valid = v; b3.in_data = d; b3.out_ready = r; end
    endcase
  endtask

  function automatic logic rdy(int sel);
    case (sel)
      0: return b0.in_ready;
      1: return b1.in_ready;
      2: return b2.in_ready;
      default: return b3.in_ready;
    endcase
  endfunction

  function automatic logic vld(int sel);
    case (sel)
      0: return b0.out_valid;
      1: return b1.out_valid;
      2: return b2.out_valid;
      default: return b3.out_valid;
    endcase
  endfunction

  function automatic logic [11:0] odata(int sel);
    case (sel)
      0: return {4'h0, b0.out_data};
      1: return {4'h0, b1.out_data};
      2: return b2.out_data;
      default: return b3.out_data;
    endcase
  endfunction

  function automatic logic [3:0] oshift(int sel);
    case (sel)
      0: return {1'b0, b0.out_shift};
      1: return {1'b0, b1.out_shift};
      2: return b2.out_shift;
      default: return b3.out_shift;
    endcase
  endfunction

  function automatic logic ozero(int sel);
    case (sel)
      0: return b0.out_zero;
      1: return b1.out_zero;
      2: return b2.out_zero;
      default: return b3.out_zero;
    endcase
  endfunction

  // Reference: walk from the MSB (L) or LSB (R) to the first set bit.
  task automatic model(int sel, logic [11:0] d, output logic [11:0] od,
                       output int os, output logic oz);
    int w;
    w  = w_of(sel);
    os = 0;
    oz = (d == 12'h0);
    od = 12'h0;
    if (!oz) begin
      if (left_of(sel)) begin
        while (!d[w-1-os]) os++;
        od = (d << os) & mask_of(sel);
      end else begin
        while (!d[os]) os++;
        od = d >> os;
      end
    end
  endtask

  // Edges after acceptance up to the first edge that samples out_valid high.
  function automatic int exp_lat(int sel, int os, logic oz);
    int sw;
    int p;
    sw = $clog2(w_of(sel));
    p  = 0;
    if (oz) return 1;
`ifdef BARREL_NORMALIZER_EARLY_EXIT_EN
    if (os == 0) return 1;
    while (((os >> p) & 1) == 0) p++;
    return sw - p + 1;
`else
    return sw + 1 + p;
`endif
  endfunction

  task automatic do_case(int sel, logic [11:0] d, int hold);
    logic [11:0] ed;
    logic [11:0] rt;
    int          es;
    logic        ez;
    int          lat;
    int          bnd;
    string       t;
    t = $sformatf("u%0d_d%0h", sel, d);
    model(sel, d, ed, es, ez);
    set_in(sel, 1'b1, d, 1'b0);
    bnd = 0;
    while (!rdy(sel) && bnd < 64) begin
      @(posedge clk); #1;
      bnd++;
    end
    check({t, "_accept_to"}, 32'(rdy(sel)), 32'd1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 12'h0, 1'b0);
    lat = 1;
    while (!vld(sel) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({t, "_latency"}, 32'(lat), 32'(exp_lat(sel, es, ez)));
    check({t, "_data"}, 32'(odata(sel)), 32'(ed));
    check({t, "_shift"}, 32'(oshift(sel)), 32'(es));
    check({t, "_zero"}, 32'(ozero(sel)), 32'(ez));
    if (left_of(sel)) rt = odata(sel) >> oshift(sel);
    else              rt = (odata(sel) << oshift(sel)) & mask_of(sel);
    check({t, "_roundtrip"}, 32'(rt), 32'(d));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({t, "_hold_valid"}, 32'(vld(sel)), 32'd1);
      check({t, "_hold_ready"}, 32'(rdy(sel)), 32'd0);
      check({t, "_hold_data"}, 32'(odata(sel)), 32'(ed));
      check({t, "_hold_shift"}, 32'(oshift(sel)), 32'(es));
    end
    set_in(sel, 1'b0, 12'h0, 1'b1);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 12'h0, 1'b0);
    check({t, "_post_valid"}, 32'(vld(sel)), 32'd0);
    check({t, "_post_ready"}, 32'(rdy(sel)), 32'd1);
  endtask

  initial begin
    logic [11:0] d;
    int          k;
    for (int s = 0; s < 4; s++) set_in(s, 1'b0, 12'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_ready%0d", s), 32'(rdy(s)), 32'd0);
      check($sformatf("rst_valid%0d", s), 32'(vld(s)), 32'd0);
      check($sformatf("rst_data%0d", s), 32'(odata(s)), 32'd0);
      check($sformatf("rst_shift%0d", s), 32'(oshift(s)), 32'd0);
      check($sformatf("rst_zero%0d", s), 32'(ozero(s)), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 4; s++)
      check($sformatf("rel_ready%0d", s), 32'(rdy(s)), 32'd1);

    do_case(0, 12'h013, 0);
    do_case(1, 12'h028, 0);
    do_case(2, 12'h001, 0);
    do_case(3, 12'h800, 0);
    for (int s = 0; s < 4; s++) do_case(s, 12'h000, 0);
    do_case(0, 12'h013, 5);
    do_case(0, 12'h080, 0);
    do_case(1, 12'h001, 0);

    set_in(0, 1'b1, 12'h037, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 12'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(vld(0)), 32'd0);
    check("midrst_ready", 32'(rdy(0)), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", 32'(rdy(0)), 32'd1);
    check("midrst_rel_valid", 32'(vld(0)), 32'd0);
    do_case(0, 12'h001, 0);

    for (int r = 0; r < 30; r++) begin
      for (int s = 0; s < 4; s++) begin
        d = 12'($urandom) & mask_of(s);
        k = $urandom_range(0, w_of(s) - 1);
        if (left_of(s)) d = d >> k;
        else            d = (d << k) & mask_of(s);
        if ($urandom_range(0, 15) == 0) d = 12'h0;
        do_case(s, d, $urandom_range(0, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
